pll_lock_sequencer: RTL



---
 rtl/pll_lock_sequencer_if.sv | 33 +++
 rtl/pll_lock_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings:
// the raw rPLL LOCK and relock request in, PLL/core resets and status out.
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;

    // Supervisor / testbench side: drives lock and requests, observes status
    modport master (
        output pll_lock,
        output force_relock,
        input  pll_reset,
        input  sys_reset,
        input  ready,
        input  fault,
        input  relock_count
    );

    // Sequencer side
    modport slave (
        input  pll_lock,
        input  force_relock,
        output pll_reset,
        output sys_reset,
        output ready,
        output fault,
        output relock_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the rPLL RESET, waits for LOCK, qualifies it for
// LOCK_STABLE cycles before releasing the core reset, retries on timeout,
// parks in FAULT after MAX_RETRIES consecutive timeouts, and re-sequences on
// lock loss or a relock request. Runs entirely on the 27 MHz input clock.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 27,
    parameter int LOCK_TIMEOUT   = 27000,
    parameter int LOCK_STABLE    = 2700,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 16
) (
    input  logic                 clkin,
    input  logic                 reset,
    pll_lock_sequencer_if.slave  bus
);
    // Retry counter only needs to reach MAX_RETRIES
    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retries_q, retries_d, retries_inc;
    logic [7:0]       relock_count_q, relock_count_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_reset_q, sys_reset_q, ready_q, fault_q;

    assign retries_inc = retries_q + RET_W'(1);

    // Two-flop synchronizer for the asynchronous rPLL LOCK
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= bus.pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state logic; lock loss is checked before any counter terminal or request
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        retries_d      = retries_q;
        relock_count_d = relock_count_q;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == RET_MAX) ? S_FAULT : S_PLL_RST;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (!lock_s_q) begin
                    // Any glitch restarts qualification without costing a retry
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    retries_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s_q) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    if (relock_count_q != 8'hFF) begin
                        relock_count_d = relock_count_q + 8'd1;
                    end
                end else if (bus.force_relock) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            end
            S_FAULT: begin
                if (bus.force_relock) begin
                    state_d   = S_PLL_RST;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered Moore output decodes share one edge
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q        <= S_PLL_RST;
            cnt_q          <= '0;
            retries_q      <= '0;
            relock_count_q <= '0;
            pll_reset_q    <= 1'b1;
            sys_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retries_q      <= retries_d;
            relock_count_q <= relock_count_d;
            pll_reset_q    <= (state_d == S_PLL_RST);
            sys_reset_q    <= (state_d != S_RUN);
            ready_q        <= (state_d == S_RUN);
            fault_q        <= (state_d == S_FAULT);
        end
    end

    assign bus.pll_reset    = pll_reset_q;
    assign bus.sys_reset    = sys_reset_q;
    assign bus.ready        = ready_q;
    assign bus.fault        = fault_q;
    assign bus.relock_count = relock_count_q;
endmodule
